// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// seq_shift_add_multiplier : N-cycle shift-and-add unsigned multiplier
// Revision 1.0
// ============================================================================
module seq_shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int            CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [N-1:0]   mcand;
  logic [2*N-1:0] p;
  logic [2*N-1:0] p_next;
  logic [CW-1:0]  cnt;

  logic           load;
  logic           step;
  logic           last;

  logic [N-1:0]   addend;
  logic [N-1:0]   sum;
  logic [N:0]     carry;

  // Multiplicand is only added when the current multiplier LSB is set.
  assign addend   = p[0] ? mcand : '0;
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_rca
    assign sum[i]     = p[N+i] ^ addend[i] ^ carry[i];
    assign carry[i+1] = (p[N+i] & addend[i]) | (p[N+i] & carry[i]) | (addend[i] & carry[i]);
  end

  // Carry-out re-enters at the top so the running sum never overflows 2N bits.
  assign p_next = {carry[N], sum, p[N-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == C_LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      p       <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      mcand <= a;
      p     <= {{N{1'b0}}, b};
      cnt   <= '0;
    end else if (step) begin
      p <= p_next;
      // Counter parks on its final value instead of wrapping past N-1.
      if (last) begin
        product <= p_next;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule
`default_nettype wire
